// File: rtl/paddle_ctrl.sv
// Paddle position controller: banks rotary step pulses into a saturating signed
// backlog and slews the paddle one STEP per frame, clamped to the playfield.
module paddle_ctrl #(
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned PADDLE_H    = 64,
  parameter int unsigned STEP        = 8,
  parameter int unsigned POS_W       = 10,
  parameter int unsigned MAX_PENDING = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             left_op,
  input  logic             right_op,
  input  logic             frame_tick,
  input  logic             center_req,
  output logic [POS_W-1:0] paddle_y,
  output logic             moving,
  output logic             at_top,
  output logic             at_bottom
);

  localparam int unsigned BW = 5;
  localparam int unsigned SW = BW + 1;
  localparam int unsigned PW = POS_W + 1;

  localparam logic [PW-1:0]        Y_MAX  = PW'(SCREEN_H - PADDLE_H);
  localparam logic [PW-1:0]        Y_C    = PW'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [PW-1:0]        STEP_W = PW'(STEP);
  localparam logic signed [SW-1:0] MAXP   = SW'(MAX_PENDING);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SLEW_UP  = 2'd1,
    SLEW_DN  = 2'd2,
    RECENTER = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [POS_W-1:0]     y_q, y_d;
  logic signed [BW-1:0] backlog_q, backlog_d;
  logic                 pend_q, pend_d;
  logic                 moving_q, moving_d;

  logic [PW-1:0]        y_ext;
  logic signed [SW-1:0] delta;
  logic signed [SW-1:0] base;
  logic signed [SW-1:0] adj;
  logic signed [SW-1:0] sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      y_q       <= POS_W'(Y_C);
      backlog_q <= '0;
      pend_q    <= 1'b0;
      moving_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      backlog_q <= backlog_d;
      pend_q    <= pend_d;
      moving_q  <= moving_d;
    end
  end

  // Move decision uses the registered state, so a pulse on the tick cycle only
  // lands in the backlog and never alters the step taken on that tick.
  always_comb begin
    y_d       = y_q;
    pend_d    = pend_q | center_req;
    base      = {backlog_q[BW-1], backlog_q};
    adj       = '0;
    delta     = '0;
    sum       = '0;
    backlog_d = backlog_q;
    state_d   = IDLE;
    moving_d  = 1'b0;
    y_ext     = {1'b0, y_q};

    if (right_op && !left_op) begin
      delta = SW'(1);
    end else if (left_op && !right_op) begin
      delta = -SW'(1);
    end

    if (frame_tick) begin
      case (state_q)
        SLEW_UP: begin
          if (y_q == '0) begin
            base = '0;
          end else begin
            y_d = (y_ext < STEP_W) ? '0 : POS_W'(y_ext - STEP_W);
            adj = SW'(1);
          end
        end
        SLEW_DN: begin
          if (y_ext == Y_MAX) begin
            base = '0;
          end else begin
            y_d = ((y_ext + STEP_W) > Y_MAX) ? POS_W'(Y_MAX) : POS_W'(y_ext + STEP_W);
            adj = -SW'(1);
          end
        end
        RECENTER: begin
          y_d    = POS_W'(Y_C);
          pend_d = 1'b0;
        end
        default: ;
      endcase
    end

    sum = base + adj + delta;
    if (sum > MAXP) begin
      sum = MAXP;
    end else if (sum < -MAXP) begin
      sum = -MAXP;
    end
    backlog_d = BW'(sum);

    if (frame_tick && state_q == RECENTER) begin
      backlog_d = '0;
    end

    if (pend_d) begin
      state_d = RECENTER;
    end else if (backlog_d[BW-1]) begin
      state_d = SLEW_UP;
    end else if (backlog_d != '0) begin
      state_d = SLEW_DN;
    end
    moving_d = (backlog_d != '0);
  end

  assign paddle_y  = y_q;
  assign moving    = moving_q;
  assign at_top    = (y_q == '0);
  assign at_bottom = ({1'b0, y_q} == Y_MAX);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: default playfield plus a tiny playfield
// instance where the reset position sits inside one STEP of both walls.
module tb_paddle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       left_op = 1'b0, right_op = 1'b0, frame_tick = 1'b0, center_req = 1'b0;
  logic [9:0] paddle_y;
  logic       moving, at_top, at_bottom;

  logic       l2 = 1'b0, r2 = 1'b0, t2 = 1'b0, c2 = 1'b0;
  logic [6:0] y2;
  logic       mv2, top2, bot2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string tag;
    bit    dut2;
    int    y;
    bit    mv;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  paddle_ctrl u_dut (
    .clk(clk), .rst(rst), .left_op(left_op), .right_op(right_op),
    .frame_tick(frame_tick), .center_req(center_req),
    .paddle_y(paddle_y), .moving(moving), .at_top(at_top), .at_bottom(at_bottom)
  );

  // Y_MAX = 10, Y_C = 5, STEP = 8
  paddle_ctrl #(.SCREEN_H(74), .PADDLE_H(64), .STEP(8), .POS_W(7), .MAX_PENDING(7)) u_dut2 (
    .clk(clk), .rst(rst), .left_op(l2), .right_op(r2),
    .frame_tick(t2), .center_req(c2),
    .paddle_y(y2), .moving(mv2), .at_top(top2), .at_bottom(bot2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive1(input logic l, input logic r, input logic t, input logic c);
    left_op = l; right_op = r; frame_tick = t; center_req = c;
    @(posedge clk); #1;
    left_op = 1'b0; right_op = 1'b0; frame_tick = 1'b0; center_req = 1'b0;
  endtask

  task automatic drive2(input logic l, input logic r, input logic t);
    l2 = l; r2 = r; t2 = t;
    @(posedge clk); #1;
    l2 = 1'b0; r2 = 1'b0; t2 = 1'b0;
  endtask

  task automatic push(input string tag, input bit d2, input int y, input bit mv);
    exp_t e;
    e.tag = tag; e.dut2 = d2; e.y = y; e.mv = mv;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    int   ymax;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e    = sb.pop_front();
      ymax = e.dut2 ? 10 : 416;
      if (e.dut2) begin
        chk({e.tag, "_y"}, int'(y2), e.y);
        chk({e.tag, "_mv"}, int'(mv2), int'(e.mv));
        chk({e.tag, "_top"}, int'(top2), int'(e.y == 0));
        chk({e.tag, "_bot"}, int'(bot2), int'(e.y == ymax));
      end else begin
        chk({e.tag, "_y"}, int'(paddle_y), e.y);
        chk({e.tag, "_mv"}, int'(moving), int'(e.mv));
        chk({e.tag, "_top"}, int'(at_top), int'(e.y == 0));
        chk({e.tag, "_bot"}, int'(at_bottom), int'(e.y == ymax));
      end
    end
  endtask

  task automatic tick1(input string tag, input int y, input bit mv, input logic l, input logic r);
    push(tag, 1'b0, y, mv);
    drive1(l, r, 1'b1, 1'b0);
    check_pop();
  endtask

  task automatic tick2(input string tag, input int y, input bit mv);
    push(tag, 1'b1, y, mv);
    drive2(1'b0, 1'b0, 1'b1);
    check_pop();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_y", int'(paddle_y), 208);
    chk("rst_mv", int'(moving), 0);
    chk("rst_top", int'(at_top), 0);
    chk("rst_bot", int'(at_bottom), 0);
    chk("rst2_y", int'(y2), 5);

    // simultaneous left+right cancel
    repeat (10) drive1(1'b1, 1'b1, 1'b0, 1'b0);
    chk("both_mv", int'(moving), 0);
    tick1("both_tick", 208, 1'b0, 1'b0, 1'b0);

    // three right pulses, four frames
    repeat (3) drive1(1'b0, 1'b1, 1'b0, 1'b0);
    chk("r3_mv", int'(moving), 1);
    tick1("r3_t1", 216, 1'b1, 1'b0, 1'b0);
    tick1("r3_t2", 224, 1'b1, 1'b0, 1'b0);
    tick1("r3_t3", 232, 1'b0, 1'b0, 1'b0);
    tick1("r3_t4", 232, 1'b0, 1'b0, 1'b0);

    // backlog saturation at -7
    do_reset();
    repeat (20) drive1(1'b1, 1'b0, 1'b0, 1'b0);
    chk("l20_mv", int'(moving), 1);
    for (int k = 1; k <= 7; k++) begin
      tick1($sformatf("l20_t%0d", k), 208 - 8 * k, (k != 7), 1'b0, 1'b0);
    end
    tick1("l20_t8", 152, 1'b0, 1'b0, 1'b0);

    // slew to bottom wall with backlog +5, then recenter
    do_reset();
    repeat (7) drive1(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      tick1($sformatf("dn_t%0d", k), 208 + 8 * k, 1'b1, 1'b0, 1'b1);
    end
    tick1("dn_t25", 408, 1'b1, 1'b0, 1'b0);
    tick1("dn_t26", 416, 1'b1, 1'b0, 1'b0);
    drive1(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ctr_hold_y", int'(paddle_y), 416);
    tick1("ctr_tick", 208, 1'b0, 1'b0, 1'b1);
    tick1("ctr_after", 208, 1'b0, 1'b0, 1'b0);

    // small playfield: clamp at top, then flush; clamp at bottom, then flush
    do_reset();
    chk("sm_rst_y", int'(y2), 5);
    repeat (3) drive2(1'b1, 1'b0, 1'b0);
    chk("sm_l3_mv", int'(mv2), 1);
    tick2("sm_up1", 0, 1'b1);
    tick2("sm_flush_top", 0, 1'b0);
    tick2("sm_idle_top", 0, 1'b0);
    repeat (3) drive2(1'b0, 1'b1, 1'b0);
    tick2("sm_dn1", 8, 1'b1);
    tick2("sm_dn2", 10, 1'b1);
    tick2("sm_flush_bot", 10, 1'b0);

    // asynchronous reset mid-slew
    do_reset();
    repeat (3) drive1(1'b0, 1'b1, 1'b0, 1'b0);
    tick1("ar_t1", 216, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_async_y", int'(paddle_y), 208);
    chk("ar_async_mv", int'(moving), 0);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    chk("ar_tick_in_rst_y", int'(paddle_y), 208);
    rst = 1'b0;
    @(posedge clk); #1;
    tick1("ar_after", 208, 1'b0, 1'b0, 1'b0);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
